// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared types, constants and cosine index folding for the DCT MAC
`timescale 1ns/1ps
package dct_pkg;

  localparam int COS_FRAC_BITS = 10;
  localparam int PIX_W         = 8;
  localparam int LEVEL_SHIFT   = 128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;

  typedef logic signed [31:0] coeff_t;

  // Folds c(k)*cos((2n+1)k*pi/16) onto {sign, m} with the value equal to
  // sign * cos(m*pi/16), m in 1..7. The k=0 normalisation 1/sqrt(2) is
  // cos(pi/4), so k=0 lands on m=4 with a positive sign.
  function automatic logic [3:0] cos_fold(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    logic       neg;
    // angle in units of pi/16, reduced mod 32 by the 5-bit product
    m = {2'b00, k} * {1'b0, n, 1'b1};
    if (m > 5'd16) m = 5'd0 - m;
    neg = (m > 5'd8);
    if (neg) m = 5'd16 - m;
    if (k == 3'd0) begin
      m   = 5'd4;
      neg = 1'b0;
    end
    return {neg, m[2:0]};
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// rtl/dct_cos_rom.sv - combinational Q.10 2-D DCT cosine term for (k1,k2,n1,n2)
`timescale 1ns/1ps
module dct_cos_rom
  import dct_pkg::*;
(
  input  logic [2:0]         k1,
  input  logic [2:0]         k2,
  input  logic [2:0]         n1,
  input  logic [2:0]         n2,
  output logic signed [31:0] cos_term
);

  // round(256 * cos(a*pi/16) * cos(b*pi/16)); 256 = 1024/4 carries the
  // 1/4 normalisation, and the table is symmetric in (a,b)
  function automatic logic [7:0] cos_mag(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] lo;
    logic [2:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    case ({lo, hi})
      6'o11: cos_mag = 8'd246;  6'o12: cos_mag = 8'd232;  6'o13: cos_mag = 8'd209;
      6'o14: cos_mag = 8'd178;  6'o15: cos_mag = 8'd139;  6'o16: cos_mag = 8'd96;
      6'o17: cos_mag = 8'd49;   6'o22: cos_mag = 8'd219;  6'o23: cos_mag = 8'd197;
      6'o24: cos_mag = 8'd167;  6'o25: cos_mag = 8'd131;  6'o26: cos_mag = 8'd91;
      6'o27: cos_mag = 8'd46;   6'o33: cos_mag = 8'd177;  6'o34: cos_mag = 8'd151;
      6'o35: cos_mag = 8'd118;  6'o36: cos_mag = 8'd81;   6'o37: cos_mag = 8'd42;
      6'o44: cos_mag = 8'd128;  6'o45: cos_mag = 8'd101;  6'o46: cos_mag = 8'd69;
      6'o47: cos_mag = 8'd35;   6'o55: cos_mag = 8'd79;   6'o56: cos_mag = 8'd54;
      6'o57: cos_mag = 8'd28;   6'o66: cos_mag = 8'd37;   6'o67: cos_mag = 8'd19;
      6'o77: cos_mag = 8'd10;
      default: cos_mag = 8'd0;
    endcase
  endfunction

  logic [3:0] f1;
  logic [3:0] f2;
  logic [7:0] mag;

  // sign-magnitude lookup keeps antisymmetric basis rows exactly cancelling
  always_comb begin
    f1       = cos_fold(k1, n1);
    f2       = cos_fold(k2, n2);
    mag      = cos_mag(f1[2:0], f2[2:0]);
    cos_term = $signed({24'd0, mag});
    if (f1[3] ^ f2[3]) cos_term = -$signed({24'd0, mag});
  end

endmodule

// File: rtl/dct_coeff_mac.sv
// rtl/dct_coeff_mac.sv - sequential 64-tap MAC producing one 8x8 DCT coefficient per request
`timescale 1ns/1ps
module dct_coeff_mac
  import dct_pkg::*;
#(
  parameter int LEVEL_SHIFT_EN = 1,
  parameter int FRAC_BITS      = COS_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       k1,
  input  logic [2:0]       k2,
  output logic             pix_rd,
  output logic [5:0]       pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  output logic [31:0]      coeff,
  output logic             coeff_valid,
  input  logic             coeff_ready,
  output logic             busy
);

  mac_state_t        state;
  mac_state_t        state_nxt;
  logic [5:0]        cnt;
  logic [2:0]        k1_q;
  logic [2:0]        k2_q;
  logic [5:0]        n_d;
  logic              rd_d;
  logic signed [8:0] p;
  coeff_t            cos_term;
  coeff_t            prod;
  coeff_t            acc;
  coeff_t            acc_sum;
  coeff_t            coeff_q;
  logic              valid_q;
  logic              accept;

  assign accept = (state == IDLE) && start;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 6'd63) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (valid_q && coeff_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state; pix_addr holds the last address after RUN
  always_comb begin
    pix_rd      = (state == RUN);
    busy        = (state != IDLE);
    pix_addr    = cnt;
    coeff       = coeff_q;
    coeff_valid = valid_q;
  end

  // address counter and coefficient index capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 6'd0;
      k1_q <= 3'd0;
      k2_q <= 3'd0;
    end else if (accept) begin
      cnt  <= 6'd0;
      k1_q <= k1;
      k2_q <= k2;
    end else if (state == RUN && cnt != 6'd63) begin
      cnt <= cnt + 6'd1;
    end
  end

  // delay the read strobe and {n1,n2} to line up with returning pix_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d <= 1'b0;
      n_d  <= 6'd0;
    end else begin
      rd_d <= pix_rd;
      n_d  <= cnt;
    end
  end

  dct_cos_rom u_rom (
    .k1       (k1_q),
    .k2       (k2_q),
    .n1       (n_d[5:3]),
    .n2       (n_d[2:0]),
    .cos_term (cos_term)
  );

  // level-shifted pixel times cosine term, in the pix_data return cycle
  always_comb begin
    p = $signed({1'b0, pix_data});
    if (LEVEL_SHIFT_EN != 0) p = $signed({1'b0, pix_data}) - $signed(9'(LEVEL_SHIFT));
    prod    = $signed({{23{p[8]}}, p}) * cos_term;
    acc_sum = acc + prod;
  end

  // accumulator, cleared on acceptance and stepped on every aligned return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (accept) acc <= '0;
    else if (rd_d)   acc <= acc_sum;
  end

  // result capture leaving DRAIN; valid asserts in DONE until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coeff_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (state == DRAIN) coeff_q <= acc_sum >>> FRAC_BITS;
      valid_q <= (state == DONE) && !(valid_q && coeff_ready);
    end
  end

endmodule

// File: tb/tb_dct_coeff_mac.sv
// tb/tb_dct_coeff_mac.sv - randomized self-checking bench for dct_coeff_mac
`timescale 1ns/1ps
module tb_dct_coeff_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  k1 = 3'd0;
  logic [2:0]  k2 = 3'd0;
  logic        pix_rd;
  logic [5:0]  pix_addr;
  logic [7:0]  pix_data;
  logic [31:0] coeff;
  logic        coeff_valid;
  logic        coeff_ready = 1'b0;
  logic        busy;

  int mem [64];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dct_coeff_mac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k1          (k1),
    .k2          (k2),
    .pix_rd      (pix_rd),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .coeff       (coeff),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .busy        (busy)
  );

  // pixel buffer: data one cycle after the read, junk otherwise
  always @(posedge clk) pix_data <= pix_rd ? 8'(mem[pix_addr]) : 8'($urandom);

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic real cv(input int k, input int n);
    real c;
    c = (k == 0) ? $sqrt(0.5) : 1.0;
    return c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
  endfunction

  function automatic int ref_term(input int a, input int b, input int n1, input int n2);
    real x;
    x = 256.0 * cv(a, n1) * cv(b, n2);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  function automatic int ref_coeff(input int a, input int b);
    int s;
    s = 0;
    for (int n1 = 0; n1 < 8; n1++)
      for (int n2 = 0; n2 < 8; n2++)
        s += (mem[n1 * 8 + n2] - 128) * ref_term(a, b, n1, n2);
    return s >>> 10;
  endfunction

  task automatic fill(input int rnd, input int v);
    for (int i = 0; i < 64; i++) mem[i] = rnd ? int'($urandom_range(255, 0)) : v;
  endtask

  task automatic run(input int a, input int b, input int hold, input int exp, input string tag);
    int lat;
    int nrd;
    longint held;
    @(negedge clk);
    k1 = 3'(a);
    k2 = 3'(b);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    nrd = 0;
    while (!coeff_valid && lat < 200) begin
      nrd += int'(pix_rd);
      start = 1'($urandom);
      k1 = 3'($urandom);
      k2 = 3'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 66);
    check({tag, "_reads"}, nrd, 64);
    check({tag, "_coeff"}, $signed(coeff), exp);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_addr_hold"}, pix_addr, 63);
    held = $signed(coeff);
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom);
      @(negedge clk);
      check({tag, "_bp_coeff"}, $signed(coeff), held);
      check({tag, "_bp_valid"}, coeff_valid, 1);
      check({tag, "_bp_busy"}, busy, 1);
    end
    coeff_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    coeff_ready = 1'b0;
    start = 1'b0;
    check({tag, "_post_valid"}, coeff_valid, 0);
    check({tag, "_post_busy"}, busy, 0);
    check({tag, "_post_rd"}, pix_rd, 0);
  endtask

  initial begin
    int a;
    int b;
    fill(0, 128);
    repeat (3) @(negedge clk);
    check("rst_pix_rd", pix_rd, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_coeff", coeff, 0);
    check("rst_valid", coeff_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    run(0, 0, 0, 0, "flat128");
    fill(0, 255);
    run(0, 0, 0, 1016, "flat255_k00");

    // abort mid-run, then confirm a fresh run carries no residue
    fill(1, 0);
    @(negedge clk);
    k1 = 3'd1;
    k2 = 3'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_pix_rd", pix_rd, 0);
    check("abort_pix_addr", pix_addr, 0);
    check("abort_coeff", coeff, 0);
    check("abort_valid", coeff_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 2, 0, ref_coeff(1, 2), "after_abort");

    fill(0, 255);
    run(4, 7, 0, 0, "flat255_k47");
    fill(0, 128);
    mem[0] = 255;
    run(4, 7, 0, 4, "impulse_k47");

    fill(1, 0);
    run(2, 5, 10, ref_coeff(2, 5), "backpressure");

    for (int r = 0; r < 8; r++) begin
      fill(1, 0);
      a = int'($urandom_range(7, 0));
      b = int'($urandom_range(7, 0));
      run(a, b, int'($urandom_range(3, 0)), ref_coeff(a, b), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
